uart_rx_decoder: RTL and testbench

Synthesizable UART receive decoder that samples the SoC's serial `io_uartOUT` line, recovers 8N1 frames, and presents each byte on a valid/ready stream through a small FIFO. It sits directly downstream of the Platform UART transmitter in simulation and FPGA bring-up builds, replacing bit-banged bench capture with a cycle-accurate, clocked receiver. It also flags framing errors, overruns, and an optional end-of-test character.

---
 rtl/uart_rx_decoder.sv | 140 ++++++++++++++
 tb/tb_uart_rx_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: 2-flop synchronizer, bit-timing FSM and small output FIFO.
// Optional end-of-test detection enabled by defining UART_RX_EOT_DETECT_EN.
module uart_rx_decoder #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] EOT_CHAR     = 8'h04
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       sim_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr, shift_en, push_req, ferr_set;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_nxt = START;
        cnt_clr   = 1'b1;
      end
      START: if (cnt == HALF_M1) begin
        cnt_clr   = 1'b1;
        state_nxt = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_M1) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (cnt == FULL_M1) begin
        cnt_clr = 1'b1;
        if (rxs) begin
          push_req  = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_meta   <= rxd;
      rxs       <= rx_meta;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      frame_err <= ferr_set;
      if (state == START) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Output FIFO; a push into a full FIFO is still taken when a pop frees a slot this cycle.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, push;

  assign pop       = out_valid & out_ready;
  assign full      = (count == DEPTH_C);
  assign push      = push_req & (~full | pop);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req & full & ~pop) overrun <= 1'b1;
    end
  end

`ifdef UART_RX_EOT_DETECT_EN
  // Set on any well-framed EOT byte, even one dropped by overrun.
  logic sim_end_q;
  always_ff @(posedge clock) begin
    if (reset)                              sim_end_q <= 1'b0;
    else if (push_req && shreg == EOT_CHAR) sim_end_q <= 1'b1;
  end
  assign sim_end = sim_end_q;
`else
  logic unused_eot;
  assign unused_eot = ^EOT_CHAR;
  assign sim_end    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Bench for uart_rx_decoder: frame table, multi-cycle corner sequences and a
// randomized run checked against a byte-queue reference model.
module tb_uart_rx_decoder;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // push edge = 2 sync + 1 detect + half bit + 8 data bits + stop bit
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB;
`ifdef UART_RX_EOT_DETECT_EN
  localparam int EOT_ON = 1;
`else
  localparam int EOT_ON = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       tb_ready = 1'b1;
  logic       rand_ready_en = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       out_ready;
  logic       out_valid, frame_err, overrun, sim_end;
  logic [7:0] out_data;

  assign out_ready = rand_ready_en ? rnd_ready : tb_ready;

  uart_rx_decoder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .EOT_CHAR(8'h04)) dut (
    .clock(clock), .reset(reset), .rxd(rxd),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun), .sim_end(sim_end)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rnd_ready <= 1'($urandom_range(0, 1));

  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  int         ferr_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rx_cyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_beats;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];

  initial begin
    int t0, base, f0, nbad;
    logic [7:0] d;
    bit ok;

    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b1, 1, 0};
    vecs[2] = '{8'hA3, 1'b0, 0, 1};
    vecs[3] = '{8'h41, 1'b1, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1, 0};
    vecs[5] = '{8'hFF, 1'b1, 1, 0};
    vecs[6] = '{8'h80, 1'b1, 1, 0};
    vecs[7] = '{8'h01, 1'b0, 0, 1};

    idle(4);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sim_end", sim_end, 0);
    reset = 1'b0;
    idle(4);

    foreach (vecs[i]) begin
      base = rx_q.size();
      f0   = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, t0);
      if (!vecs[i].stop_ok) begin
        idle(20);
        rxd = 1'b1;
      end
      idle(12);
      chk($sformatf("tbl%0d_beats", i), rx_q.size() - base, vecs[i].exp_beats);
      chk($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("tbl%0d_overrun", i), overrun, 0);
      if (vecs[i].exp_beats > 0 && rx_q.size() > base) begin
        chk($sformatf("tbl%0d_data", i), rx_q[base], vecs[i].data);
        chk($sformatf("tbl%0d_latency", i), rx_cyc[base] - t0, LAT);
      end
    end

    // false start: short low pulse must be rejected
    base = rx_q.size();
    f0   = ferr_cnt;
    rxd  = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(20);
    chk("fstart_beats", rx_q.size() - base, 0);
    chk("fstart_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, t0);
    idle(12);
    chk("fstart_next_beats", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("fstart_next_data", rx_q[base], 8'h3C);

    // overrun: five back-to-back frames with the consumer stalled
    tb_ready = 1'b0;
    idle(2);
    base = rx_q.size();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, t0);
      if (k == 4) begin
        chk("ovr_before_flag", overrun, 0);
        chk("ovr_before_valid", out_valid, 1);
      end
    end
    idle(2);
    chk("ovr_flag", overrun, 1);
    chk("ovr_stalled_beats", rx_q.size() - base, 0);
    tb_ready = 1'b1;
    idle(10);
    chk("ovr_drain_beats", rx_q.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (rx_q.size() > base + k) chk($sformatf("ovr_drain%0d", k), rx_q[base + k], k + 1);
    chk("ovr_drain_empty", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // reset one cycle after the third data bit of 0xFF
    base = rx_q.size();
    rxd  = 1'b0;
    idle(CPB);
    for (int k = 0; k < 3; k++) drive_bit(1'b1);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_sim_end", sim_end, 0);
    idle(100);
    chk("mid_rst_beats", rx_q.size() - base, 0);
    send_frame(8'h7E, 1'b1, t0);
    idle(12);
    chk("mid_rst_next_beats", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("mid_rst_next_data", rx_q[base], 8'h7E);

    // end-of-test character
    chk("eot_before", sim_end, 0);
    base = rx_q.size();
    send_frame(8'h04, 1'b1, t0);
    idle(2);
    chk("eot_flag", sim_end, EOT_ON);
    chk("eot_beats", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("eot_data", rx_q[base], 8'h04);
    idle(30);
    chk("eot_hold", sim_end, EOT_ON);

    // randomized frames, random consumer stalls
    rand_ready_en = 1'b1;
    base = rx_q.size();
    f0   = ferr_cnt;
    nbad = 0;
    for (int n = 0; n < 16; n++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) exp_q.push_back(d);
      else nbad++;
      send_frame(d, ok, t0);
      if (!ok) begin
        idle(20);
        rxd = 1'b1;
        idle(2);
      end
      idle($urandom_range(0, 4));
    end
    idle(60);
    rand_ready_en = 1'b0;
    chk("rnd_beats", rx_q.size() - base, exp_q.size());
    chk("rnd_ferr", ferr_cnt - f0, nbad);
    chk("rnd_overrun", overrun, 0);
    for (int k = 0; k < exp_q.size(); k++)
      if (rx_q.size() > base + k) chk($sformatf("rnd_data%0d", k), rx_q[base + k], exp_q[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
